// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a shared single-cycle ALU.
// The granted operation's result is captured into a one-entry valid/ready response buffer.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic signed [WIDTH-1:0] a0,
  input  logic signed [WIDTH-1:0] b0,
  input  logic        [2:0]       f0,
  output logic                    gnt0,
  input  logic                    req1,
  input  logic signed [WIDTH-1:0] a1,
  input  logic signed [WIDTH-1:0] b1,
  input  logic        [2:0]       f1,
  output logic                    gnt1,
  output logic signed [WIDTH-1:0] alu_a,
  output logic signed [WIDTH-1:0] alu_b,
  output logic        [2:0]       alu_f,
  input  logic signed [WIDTH-1:0] alu_y,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic signed [WIDTH-1:0] rsp_y,
  output logic                    rsp_zero,
  output logic                    rsp_err
);

  localparam logic [2:0] F_UNSUPPORTED = 3'b011;

  logic                    r_prio;
  logic                    r_vld_p1;
  logic                    r_id_p1;
  logic signed [WIDTH-1:0] r_y_p1;
  logic                    r_zero_p1;
  logic                    r_err_p1;

  logic w_slot_free;
  logic w_gnt0;
  logic w_gnt1;
  logic w_grant;
  logic w_winner;

  function automatic logic is_unsupported(input logic [2:0] f);
    return (f == F_UNSUPPORTED);
  endfunction

  function automatic logic signed [WIDTH-1:0] capture_y(input logic [2:0] f,
                                                        input logic signed [WIDTH-1:0] y);
    return is_unsupported(f) ? '0 : y;
  endfunction

  function automatic logic capture_zero(input logic [2:0] f, input logic z);
    return is_unsupported(f) ? 1'b1 : z;
  endfunction

  // Stage p0: arbitration and ALU operand steering
  assign w_slot_free = !r_vld_p1 || rsp_ready;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset && w_slot_free) begin
      if (req0 && req1) begin
        w_gnt0 = !r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign w_grant  = w_gnt0 || w_gnt1;
  assign w_winner = w_gnt1;

  assign gnt0  = w_gnt0;
  assign gnt1  = w_gnt1;
  assign alu_a = w_gnt1 ? a1 : (w_gnt0 ? a0 : '0);
  assign alu_b = w_gnt1 ? b1 : (w_gnt0 ? b0 : '0);
  assign alu_f = w_gnt1 ? f1 : (w_gnt0 ? f0 : 3'b000);

  // Stage p1: response buffer; a grant overwrites even while draining
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio    <= FIRST_PRIO;
      r_vld_p1  <= 1'b0;
      r_id_p1   <= 1'b0;
      r_y_p1    <= '0;
      r_zero_p1 <= 1'b0;
      r_err_p1  <= 1'b0;
    end else if (w_grant) begin
      r_prio    <= !w_winner;
      r_vld_p1  <= 1'b1;
      r_id_p1   <= w_winner;
      r_y_p1    <= capture_y(alu_f, alu_y);
      r_zero_p1 <= capture_zero(alu_f, alu_zero);
      r_err_p1  <= is_unsupported(alu_f);
    end else if (rsp_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_id    = r_id_p1;
  assign rsp_y     = r_y_p1;
  assign rsp_zero  = r_zero_p1;
  assign rsp_err   = r_err_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU stub
// and a response scoreboard filled on grants, drained on accepted responses.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  f0, f1;
  logic        gnt0, gnt1;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_y;

  typedef struct packed {
    logic        id;
    logic [31:0] y;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_share_arbiter #(.WIDTH(32), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .f0(f0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .f1(f1), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; the unsupported code returns junk the DUT must discard
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_y    = alu_fn(alu_a, alu_b, alu_f);
    alu_zero = (alu_f == 3'b011) ? 1'b0 : (alu_y == 32'd0);
  end

  function automatic rsp_t expect_rsp(input logic id, input logic [31:0] a,
                                      input logic [31:0] b, input logic [2:0] f);
    rsp_t r;
    r.id   = id;
    r.err  = (f == 3'b011);
    r.y    = r.err ? 32'd0 : alu_fn(a, b, f);
    r.zero = r.err ? 1'b1 : (r.y == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    rsp_t e;
    @(negedge clk);
    check("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
    if (rsp_valid && rsp_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed response y=%0h expected none", rsp_y);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_id",   {63'd0, rsp_id},   {63'd0, e.id});
        check("sb_y",    {32'd0, rsp_y},    {32'd0, e.y});
        check("sb_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
        check("sb_err",  {63'd0, rsp_err},  {63'd0, e.err});
      end
    end
    if (gnt0) sb.push_back(expect_rsp(1'b0, a0, b0, f0));
    else if (gnt1) sb.push_back(expect_rsp(1'b1, a1, b1, f1));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_y;
    reset = 1'b1; rsp_ready = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0; f0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0; f1 = '0;
    adv();
    sample();
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_id",    {63'd0, rsp_id},    64'd0);
    check("rst_y",     {32'd0, rsp_y},     64'd0);
    check("rst_zero",  {63'd0, rsp_zero},  64'd0);
    check("rst_err",   {63'd0, rsp_err},   64'd0);
    adv();
    reset = 1'b0;

    // Single ADD on port 0
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; f0 = 3'b010;
    sample();
    check("t1_gnt0",  {63'd0, gnt0},  64'd1);
    check("t1_alu_a", {32'd0, alu_a}, 64'd5);
    check("t1_alu_f", {61'd0, alu_f}, 64'd2);
    adv();
    req0 = 1'b0;
    sample();
    check("t1_valid", {63'd0, rsp_valid}, 64'd1);
    check("t1_id",    {63'd0, rsp_id},    64'd0);
    check("t1_y",     {32'd0, rsp_y},     64'd12);
    check("t1_zero",  {63'd0, rsp_zero},  64'd0);
    adv();
    sample();
    check("t1_drained", {63'd0, rsp_valid}, 64'd0);
    check("t1_y_hold",  {32'd0, rsp_y},     64'd12);
    check("t1_idle_a",  {32'd0, alu_a},     64'd0);
    adv();

    // Tie: fresh reset so FIRST_PRIO starts the rotation
    reset = 1'b1;
    sample();
    adv();
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'd10; b0 = 32'd3; f0 = 3'b010;
    req1 = 1'b1; a1 = 32'd10; b1 = 32'd3; f1 = 3'b110;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("tie_gnt0", {63'd0, gnt0}, {63'd0, (i % 2 == 0)});
      check("tie_gnt1", {63'd0, gnt1}, {63'd0, (i % 2 == 1)});
      if (i > 0) begin
        exp_y = ((i - 1) % 2 == 0) ? 32'd13 : 32'd7;
        check("tie_valid", {63'd0, rsp_valid}, 64'd1);
        check("tie_id",    {63'd0, rsp_id},    {63'd0, ((i - 1) % 2 == 1)});
        check("tie_y",     {32'd0, rsp_y},     {32'd0, exp_y});
      end
      adv();
    end
    req0 = 1'b0; req1 = 1'b0;
    sample();
    check("tie_last_id", {63'd0, rsp_id}, 64'd1);
    check("tie_last_y",  {32'd0, rsp_y},  64'd7);
    adv();
    sample();
    check("tie_drained", {63'd0, rsp_valid}, 64'd0);
    adv();

    // Signed SLT, then SUB to zero back-to-back on port 1
    req1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'd1; f1 = 3'b111;
    sample();
    check("slt_gnt1", {63'd0, gnt1}, 64'd1);
    adv();
    a1 = 32'd3; b1 = 32'd3; f1 = 3'b110;
    sample();
    check("slt_y",      {32'd0, rsp_y},    64'd1);
    check("slt_zero",   {63'd0, rsp_zero}, 64'd0);
    check("sub_gnt1",   {63'd0, gnt1},     64'd1);
    adv();
    req1 = 1'b0;
    sample();
    check("sub_y",     {32'd0, rsp_y},     64'd0);
    check("sub_zero",  {63'd0, rsp_zero},  64'd1);
    check("sub_valid", {63'd0, rsp_valid}, 64'd1);
    adv();
    sample();
    adv();

    // Backpressure stall with req0 held
    req0 = 1'b1; a0 = 32'd6; b0 = 32'd3; f0 = 3'b001;
    sample();
    check("bp_gnt0_first", {63'd0, gnt0}, 64'd1);
    adv();
    a0 = 32'd8; b0 = 32'd1; f0 = 3'b010; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_no_gnt", {63'd0, gnt0},      64'd0);
      check("bp_valid",  {63'd0, rsp_valid}, 64'd1);
      check("bp_y_hold", {32'd0, rsp_y},     64'd7);
      adv();
    end
    rsp_ready = 1'b1;
    sample();
    check("bp_release_gnt0", {63'd0, gnt0}, 64'd1);
    adv();
    req0 = 1'b0;
    sample();
    check("bp_new_y", {32'd0, rsp_y}, 64'd9);
    adv();

    // Unsupported code, then a normal AND clears the error flag
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; f0 = 3'b011;
    sample();
    check("err_gnt0", {63'd0, gnt0}, 64'd1);
    adv();
    a0 = 32'd12; b0 = 32'd10; f0 = 3'b000;
    sample();
    check("err_flag", {63'd0, rsp_err},  64'd1);
    check("err_y",    {32'd0, rsp_y},    64'd0);
    check("err_zero", {63'd0, rsp_zero}, 64'd1);
    adv();
    req0 = 1'b0;
    sample();
    check("and_err", {63'd0, rsp_err},  64'd0);
    check("and_y",   {32'd0, rsp_y},    64'd8);
    check("and_zero",{63'd0, rsp_zero}, 64'd0);
    adv();

    // Reset while a response is stalled; pointer would otherwise favour port 1
    req0 = 1'b1; a0 = 32'd2; b0 = 32'd2; f0 = 3'b010;
    sample();
    check("mr_gnt0", {63'd0, gnt0}, 64'd1);
    adv();
    req0 = 1'b0; req1 = 1'b1; a1 = 32'd1; b1 = 32'd1; f1 = 3'b010;
    rsp_ready = 1'b0; reset = 1'b1;
    sample();
    check("mr_rst_gnt0", {63'd0, gnt0},      64'd0);
    check("mr_rst_gnt1", {63'd0, gnt1},      64'd0);
    check("mr_pending",  {63'd0, rsp_valid}, 64'd1);
    adv();
    reset = 1'b0;
    sb.delete();
    req0 = 1'b1; a0 = 32'd4; b0 = 32'd4; f0 = 3'b110; rsp_ready = 1'b1;
    sample();
    check("mr_discarded", {63'd0, rsp_valid}, 64'd0);
    check("mr_tie_gnt0",  {63'd0, gnt0},      64'd1);
    check("mr_tie_gnt1",  {63'd0, gnt1},      64'd0);
    adv();
    req0 = 1'b0;
    sample();
    check("mr_id",      {63'd0, rsp_id},   64'd0);
    check("mr_zero",    {63'd0, rsp_zero}, 64'd1);
    check("mr_gnt1",    {63'd0, gnt1},     64'd1);
    adv();
    req1 = 1'b0;
    sample();
    adv();
    sample();
    check("end_valid",   {63'd0, rsp_valid},     64'd0);
    check("end_sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU between two requesters, e.g. the main datapath port and a branch/address-compare port.
- Arbitration is round-robin with a req/gnt handshake.
- The block drives the ALU a/b/f inputs from the winning requester and registers the ALU y/zero into a one-entry response buffer.
- The response buffer uses a valid/ready handshake and carries the requester id.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU (32).
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 operation request; hold until gnt0
- a0  input  WIDTH  requester 0 operand a (signed)
- b0  input  WIDTH  requester 0 operand b (signed)
- f0  input  3  requester 0 ALU function code
- gnt0  output  1  requester 0 accepted this cycle (combinational)
- req1, a1, b1, f1, gnt1  as above, for requester 1
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_f  output  3  to ALU f
- alu_y  input  WIDTH  from ALU y
- alu_zero  input  1  from ALU zero
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes response this cycle when rsp_valid
- rsp_id  output  1  requester that issued the buffered op
- rsp_y  output  WIDTH  buffered result
- rsp_zero  output  1  buffered zero flag
- rsp_err  output  1  buffered op used an unsupported f code

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_zero=0, rsp_err=0.
  - Priority pointer set so FIRST_PRIO wins the next tie.
- Slot free condition: slot_free = !rsp_valid || rsp_ready. No grant is issued unless slot_free.
- Grant logic (combinational):
  - If slot_free and exactly one req is high, that requester is granted.
  - If both are high, the requester not granted most recently wins.
  - gnt0 and gnt1 are never both high.
  - While reset is high, gnt0 = gnt1 = 0.
- Pointer update: updates only on a grant cycle, pointing priority away from the winner. With no grant, the pointer holds.
- ALU drive:
  - On a grant cycle, alu_a/alu_b/alu_f come from the winner.
  - Otherwise alu_a=0, alu_b=0, alu_f=3'b000.
  - The ALU is combinational, so alu_y/alu_zero are sampled in the same cycle.
- Capture (rising edge of a grant cycle):
  - rsp_y <= alu_y, rsp_zero <= alu_zero, rsp_id <= winner, rsp_valid <= 1.
  - Latency: gnt cycle N -> rsp_valid high in cycle N+1.
- Supported f codes: 000 AND, 001 OR, 010 ADD, 100 AND-NOT, 101 OR-NOT, 110 SUB, 111 signed SLT. Code 011 is unsupported.
- Unsupported f=3'b011 (grant still issued):
  - rsp_y <= 0, rsp_zero <= 1, rsp_err <= 1; alu_y is ignored.
  - rsp_err <= 0 for all other codes.
- Drain: rsp_valid && rsp_ready with no new grant -> rsp_valid <= 0. rsp_y/rsp_zero/rsp_id/rsp_err hold their last values.
- Simultaneous drain and grant: new result overwrites the buffer and rsp_valid stays 1, giving one response per cycle at full throughput.
- Backpressure: rsp_valid && !rsp_ready means no grants. Buffer contents hold stable, and requesters keep req asserted with operands stable.
- Requester rule: a requester may drop req only after gnt. The arbiter does not need to tolerate withdrawal, but withdrawal must not corrupt state.
- Arithmetic: no width extension; ADD/SUB wrap modulo 2^WIDTH, as in the ALU.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 next cycle) and the pointer is reinitialised. The cycle with reset high issues no grant.

Test Plan:
- After reset, req0=1, a0=5, b0=7, f0=010, rsp_ready=1 -> gnt0=1 in cycle N; rsp_valid=1, rsp_id=0, rsp_y=12, rsp_zero=0 in N+1.
- req0 and req1 held high for 4 cycles with FIRST_PRIO=0, rsp_ready=1 -> grants 0,1,0,1. rsp_valid stays high and rsp_id alternates 0,1,0,1.
- req1, a1=-1, b1=1, f1=111 (signed SLT) -> rsp_y=1, rsp_zero=0. Then a1=3, b1=3, f1=110 -> rsp_y=0, rsp_zero=1.
- First op accepted, then rsp_ready=0 for 3 cycles with req0 held -> no gnt0 during the stall and rsp_y unchanged. rsp_ready=1 -> gnt0 in that same cycle, new result next cycle.
- req0 with f0=011 -> rsp_err=1, rsp_y=0, rsp_zero=1. A following f0=000 op -> rsp_err=0.
- rsp_valid=1 and rsp_ready=0, assert reset for one cycle with req1 high -> rsp_valid=0, no gnt during reset, and the next tie is won by FIRST_PRIO.
